adc128s_fc: RTL and testbench

//  Behavioural model of an 8-channel, 12-bit SPI A2D converter (ADC128S family).
//  It sits in the Segway bench and serves four analog quantities to the A2D

---
 rtl/a2d_pkg.sv | 15 +
 rtl/spi_edge_sync.sv | 28 ++
 rtl/adc128s_fc.sv | 109 ++++++++++
 tb/tb_adc128s_fc.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared A2D definitions: channel type, channel map and SPI frame length.
// Also used by the A2D interface inside Segway, so the channel map lives here only.
package a2d_pkg;

  typedef logic [2:0] a2d_chan_t;

  localparam a2d_chan_t CH_LD_LFT  = 3'd0;
  localparam a2d_chan_t CH_LD_RGHT = 3'd4;
  localparam a2d_chan_t CH_STEER   = 3'd5;
  localparam a2d_chan_t CH_BATT    = 3'd6;

  localparam int A2D_FRAME_BITS = 16;
  localparam int A2D_DATA_BITS  = 12;

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchroniser for an asynchronous SPI pin, with one-clk rise/fall
// pulses taken from the last two stages.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {3{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_sync = r_sync[2];
  assign o_rise = r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/adc128s_fc.sv
// Behavioural ADC128S-style SPI A2D: each frame returns the channel chosen by
// the previous complete frame, and selects the channel for the next one.
module adc128s_fc
  import a2d_pkg::*;
#(
  parameter int FRAME_BITS = A2D_FRAME_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_mosi_sync;
  logic [A2D_DATA_BITS-1:0] w_sel_value;
  logic w_unused_cmd;

  logic [1:0]       r_mosi_sync;
  logic [15:0]      r_tx_shift;
  logic [15:0]      r_rx_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  a2d_chan_t        r_chan_ptr;

  spi_edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (SS_n),
    .o_sync  (w_ss_sync),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (SCLK),
    .o_sync  (w_sclk_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_sync <= 2'b00;
    end else begin
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_mosi_sync = r_mosi_sync[1];

  always_comb begin
    w_sel_value = '0;
    case (r_chan_ptr)
      CH_LD_LFT:  w_sel_value = ld_cell_lft;
      CH_LD_RGHT: w_sel_value = ld_cell_rght;
      CH_STEER:   w_sel_value = steerPot;
      CH_BATT:    w_sel_value = batt;
      default:    w_sel_value = '0;
    endcase
  end

  // The selected value is frozen at frame start; later input changes wait for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
    end else if (w_ss_fall) begin
      r_tx_shift <= {4'b0000, w_sel_value};
      r_bit_cnt  <= '0;
    end else if (!w_ss_sync) begin
      if (w_sclk_rise) begin
        r_rx_shift <= {r_rx_shift[14:0], w_mosi_sync};
        if (r_bit_cnt != FULL_CNT) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      if (w_sclk_fall) begin
        r_tx_shift <= {r_tx_shift[14:0], 1'b0};
      end
    end
  end

  // Only a frame that saw every SCLK rise may change the channel pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan_ptr <= CH_LD_LFT;
    end else if (w_ss_rise && (r_bit_cnt == FULL_CNT)) begin
      r_chan_ptr <= r_rx_shift[13:11];
    end
  end

  assign MISO = r_tx_shift[15];

  assign w_unused_cmd = ^{r_rx_shift[15:14], r_rx_shift[10:0], w_sclk_sync};

endmodule

// File: tb/tb_adc128s_fc.sv
// Directed bench for adc128s_fc: a master drives SPI frames and queues the
// hand-computed response; an independent monitor reassembles MISO and compares.
module tb_adc128s_fc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] ld_cell_lft = 12'd0;
  logic [11:0] ld_cell_rght = 12'd0;
  logic [11:0] steerPot = 12'd0;
  logic [11:0] batt = 12'd0;

  int errorCount = 0;
  int checkCount = 0;
  int frameIdx = 0;
  logic [15:0] expQ[$];

  int monCount = 0;
  logic [15:0] monWord = 16'h0000;

  adc128s_fc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame of nBits SCLK pulses; a full frame queues its expected response.
  task automatic applyStimulus(input logic [15:0] cmd, input int nBits, input bit pushExp,
                               input logic [15:0] expWord, input bit changeLft,
                               input logic [11:0] newLft);
    if (pushExp) expQ.push_back(expWord);
    SS_n = 1'b0;
    waitClk(8);
    if (changeLft) ld_cell_lft = newLft;
    for (int i = 0; i < nBits; i++) begin
      MOSI = cmd[15-i];
      waitClk(4);
      SCLK = 1'b0;
      waitClk(4);
      SCLK = 1'b1;
      waitClk(4);
    end
    SS_n = 1'b1;
    waitClk(8);
  endtask

  always @(negedge SS_n) begin
    monCount = 0;
    monWord  = 16'h0000;
  end

  // MISO is sampled just before each SCLK fall, before the DUT shifts the next bit out.
  always @(negedge SCLK) begin
    if (SS_n === 1'b0) begin
      monWord = {monWord[14:0], MISO};
      monCount++;
    end
  end

  always @(posedge SS_n) begin
    if (monCount == 16) begin
      frameIdx++;
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL frame%0d: got %h, expected no frame", frameIdx, monWord);
      end else begin
        checkOutput($sformatf("frame%0d", frameIdx), monWord, expQ.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitClk(3);
    #1;
    checkOutput("resetMiso", {15'd0, MISO}, 16'h0000);
    rst_n = 1'b1;
    waitClk(5);
    checkOutput("idleMiso", {15'd0, MISO}, 16'h0000);

    // Default channel 0 after reset
    ld_cell_lft = 12'd350;
    applyStimulus(16'h0000, 16, 1'b1, 16'h015E, 1'b0, 12'd0);
    applyStimulus(16'h0000, 16, 1'b1, 16'h015E, 1'b0, 12'd0);

    // Select ch4, read it back next frame
    ld_cell_rght = 12'd500;
    applyStimulus(16'h2000, 16, 1'b1, 16'h015E, 1'b0, 12'd0);
    applyStimulus(16'h0000, 16, 1'b1, 16'h01F4, 1'b0, 12'd0);

    // Pipelined ch5, ch6, ch0
    steerPot = 12'h800;
    batt     = 12'hFE0;
    applyStimulus(16'h2800, 16, 1'b1, 16'h015E, 1'b0, 12'd0);
    applyStimulus(16'h3000, 16, 1'b1, 16'h0800, 1'b0, 12'd0);
    applyStimulus(16'h0000, 16, 1'b1, 16'h0FE0, 1'b0, 12'd0);

    // Aborted frame must not change the selection
    applyStimulus(16'h3000, 16, 1'b1, 16'h015E, 1'b0, 12'd0);
    applyStimulus(16'h2800, 8, 1'b0, 16'h0000, 1'b0, 12'd0);
    applyStimulus(16'h0000, 16, 1'b1, 16'h0FE0, 1'b0, 12'd0);

    // Input changes mid-frame only affect the following frame
    applyStimulus(16'h0000, 16, 1'b1, 16'h015E, 1'b1, 12'd0);
    applyStimulus(16'h0000, 16, 1'b1, 16'h0000, 1'b0, 12'd0);

    // Reset mid-frame after selecting ch6
    ld_cell_lft = 12'hABC;
    applyStimulus(16'h3000, 16, 1'b1, 16'h0ABC, 1'b0, 12'd0);
    SS_n = 1'b0;
    waitClk(8);
    for (int i = 0; i < 6; i++) begin
      MOSI = 1'b0;
      waitClk(4);
      SCLK = 1'b0;
      waitClk(4);
      SCLK = 1'b1;
      waitClk(4);
    end
    checkOutput("preResetMiso", {15'd0, MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetMiso", {15'd0, MISO}, 16'h0000);
    waitClk(2);
    SS_n = 1'b1;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(6);
    applyStimulus(16'h0000, 16, 1'b1, 16'h0ABC, 1'b0, 12'd0);

    waitClk(20);
    checkOutput("queueEmpty", 16'(expQ.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
